fabric2_port_arbiter: RTL and testbench
=======================================

# fabric2_port_arbiter

Registered arbiter for the version-2 system fabric. It shares slave ports p0..p4 between the instruction (I) and data (D) masters. Each port is locked to one master from grant until that master's transaction completes. The block drives the master and slave switch selects from registered ownership state, so the crossbar never sees combinational request-to-select paths. Contention on a single port is resolved by fixed data priority or by round-robin, selected at compile time.

## Interface
- PORTNO_WIDTH, 11, width of port number and master switch selects
- clk  in  1  fabric clock
- nrst  in  1  reset, asynchronous, active-low
- i_I_req  in  1  I master request; level, held with i_I_portno stable until o_I_gnt
- i_I_portno  in  PORTNO_WIDTH  I destination port
- i_I_done  in  1  I transaction complete; one-cycle pulse while o_I_gnt=1
- i_D_req  in  1  D master request; same rules as i_I_req
- i_D_portno  in  PORTNO_WIDTH  D destination port
- i_D_done  in  1  D transaction complete; same rules as i_I_done
- o_I_gnt  out  1  I owns its port; may issue OCP commands
- o_D_gnt  out  1  D owns its port
- o_I_mswitch  out  PORTNO_WIDTH  I master switch select (granted port)
- o_D_mswitch  out  PORTNO_WIDTH  D master switch select
- o_p0_sswitch..o_p4_sswitch  out  1 each  slave switch select: 0 = I master, 1 = D master
- o_wait_cnt  out  16  saturating count of cycles any request waited on a busy or lost port

## Operation
- Per-master FSM: M_IDLE -> M_WAIT on req -> M_OWN on grant -> M_IDLE on done.
  - Grant is issued at the first edge where the port is free.
  - A req already granted at its first edge goes M_IDLE -> M_OWN directly.
- Per-port owner register: NONE / I / D.
- A port is free at an edge when:
  - its owner is NONE, or
  - its owner's done is asserted in that cycle. Handover to a waiting master happens on the same edge that frees the port.
- Both masters requesting the same free port in the same cycle:
  - Default: D wins.
  - The loser stays in M_WAIT and increments o_wait_cnt each cycle it waits.
- Different ports: both masters are granted in the same cycle.
- Out-of-range port (portno >= 5):
  - Granted next edge with no lock and no sswitch change.
  - mswitch is still driven to portno, so the fabric error path responds.
- req asserted while in M_OWN: ignored.
- done asserted while not in M_OWN: ignored.
- sswitch for a port:
  - 0 when its owner is I.
  - 1 otherwise, i.e. D or NONE.
- mswitch:
  - Loaded with portno on the grant edge.
  - Held after release until the next grant.
- o_wait_cnt:
  - Increments by 1 per cycle in which at least one master is in M_WAIT, or lost arbitration this cycle.
  - Saturates at 16'hFFFF.

## Timing
- Reset values: gnt=0, mswitch=0, all sswitch=1, owners NONE, FSMs M_IDLE, o_wait_cnt=0, RR pointer=I-last (next conflict goes to D).
- Grant latency on a free port: req sampled at edge N, o_X_gnt=1 after edge N. Switch selects are valid in the same cycle as gnt.
- Release: done in cycle N, so gnt=0 and the owner is freed after edge N. A waiting master's gnt=1 also appears after edge N, with zero bubble.
- A master dropping req before gnt returns to M_IDLE on the next edge; no grant is issued.
- Reset mid-transaction: all state returns to reset values immediately, asynchronously. Masters must restart.
- All outputs come directly from registers; none depends combinationally on inputs.

## Configuration
- FABRIC2_ARB_RR_EN defined:
  - A single last-winner bit alternates priority on same-port, same-cycle conflicts.
  - The bit updates only on conflicts.
- Not defined: D always wins conflicts, and no pointer register exists.

## Test plan
- Reset: nrst=0 mid-run -> gnt=0, sswitch=5'b11111, mswitch=0, o_wait_cnt=0.
- I req port 2, D req port 3, same cycle -> both gnt after 1 edge, p2_sswitch=0, p3_sswitch=1, o_I_mswitch=2, o_D_mswitch=3, wait_cnt=0.
- Both req port 1, same cycle, RR off -> D gnt, I waits. D done after 4 cycles -> I gnt on the same edge D releases, p1_sswitch goes 1->0, wait_cnt=5.
- With FABRIC2_ARB_RR_EN, three back-to-back port-0 conflicts -> winners D, I, D.
- I req port 7 -> gnt after 1 edge, o_I_mswitch=7, all sswitch unchanged. Done releases with no owner change.
- D holds port 4 for 70000 cycles while I waits -> o_wait_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/fabric2_port_arbiter.sv
// fabric2_port_arbiter
// Shares slave ports p0..p4 of the version-2 fabric between the instruction (I)
// and data (D) masters. A port is locked to one master from grant until that
// master's done pulse. Every output comes straight from a register, so the
// crossbar never sees a combinational request-to-select path.
//
// Ports:
//   clk, nrst                    fabric clock, asynchronous active-low reset
//   i_I_req/i_I_portno/i_I_done  I master request, destination port, completion
//   i_D_req/i_D_portno/i_D_done  D master request, destination port, completion
//   o_I_gnt, o_D_gnt             master owns its port
//   o_I_mswitch, o_D_mswitch     master switch select (last granted port number)
//   o_p0_sswitch..o_p4_sswitch   slave switch select: 0 = I master, 1 = D master
//   o_wait_cnt                   saturating count of cycles spent waiting
//
// Compile-time option:
//   FABRIC2_ARB_RR_EN  when defined, same-port same-cycle conflicts alternate
//                      between the masters; otherwise D always wins.
module fabric2_port_arbiter #(
  parameter int PORTNO_WIDTH = 11
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    i_I_req,
  input  logic [PORTNO_WIDTH-1:0] i_I_portno,
  input  logic                    i_I_done,
  input  logic                    i_D_req,
  input  logic [PORTNO_WIDTH-1:0] i_D_portno,
  input  logic                    i_D_done,
  output logic                    o_I_gnt,
  output logic                    o_D_gnt,
  output logic [PORTNO_WIDTH-1:0] o_I_mswitch,
  output logic [PORTNO_WIDTH-1:0] o_D_mswitch,
  output logic                    o_p0_sswitch,
  output logic                    o_p1_sswitch,
  output logic                    o_p2_sswitch,
  output logic                    o_p3_sswitch,
  output logic                    o_p4_sswitch,
  output logic [15:0]             o_wait_cnt
);

  localparam int NUM_PORTS = 5;
  localparam logic [PORTNO_WIDTH-1:0] PORT_LIMIT = PORTNO_WIDTH'(NUM_PORTS);

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_WAIT = 2'd1,
    M_OWN  = 2'd2
  } mstate_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  mstate_e                i_state_r, i_state_s;
  mstate_e                d_state_r, d_state_s;
  owner_e                 owner_r [NUM_PORTS];
  owner_e                 owner_s [NUM_PORTS];
  logic [NUM_PORTS-1:0]   sswitch_r;
  logic [NUM_PORTS-1:0]   port_free_s;
  logic                   i_cand_s, d_cand_s;
  logic                   i_inr_s, d_inr_s;
  logic                   i_rel_s, d_rel_s;
  logic                   i_free_s, d_free_s;
  logic                   conflict_s;
  logic                   d_pri_s;
  logic                   i_grant_s, d_grant_s;
  logic                   wait_s;
  logic [15:0]            wait_cnt_s;

  // Per-master FSM transition; req is ignored while owning, done is ignored otherwise.
  function automatic mstate_e next_mstate(input mstate_e cur, input logic grant,
                                          input logic req, input logic done);
    mstate_e nxt;
    case (cur)
      M_IDLE, M_WAIT: begin
        if (grant) nxt = M_OWN;
        else if (req) nxt = M_WAIT;
        else nxt = M_IDLE;
      end
      M_OWN: begin
        if (done) nxt = M_IDLE;
        else nxt = M_OWN;
      end
      default: nxt = M_IDLE;
    endcase
    return nxt;
  endfunction

`ifdef FABRIC2_ARB_RR_EN
  // Last conflict winner: 0 = I won last (D goes next), 1 = D won last.
  logic rr_last_d_r;

  assign d_pri_s = ~rr_last_d_r;

  // Round-robin pointer flips only when a same-port conflict is resolved.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rr_last_d_r <= 1'b0;
    end else if (conflict_s) begin
      rr_last_d_r <= d_pri_s;
    end else begin
      rr_last_d_r <= rr_last_d_r;
    end
  end
`else
  assign d_pri_s = 1'b1;
`endif

  // Arbitration, next-state and next-owner decisions from registered state and inputs.
  always_comb begin
    i_cand_s    = i_I_req && (i_state_r != M_OWN);
    d_cand_s    = i_D_req && (d_state_r != M_OWN);
    i_inr_s     = (i_I_portno < PORT_LIMIT);
    d_inr_s     = (i_D_portno < PORT_LIMIT);
    i_rel_s     = i_I_done && (i_state_r == M_OWN);
    d_rel_s     = i_D_done && (d_state_r == M_OWN);
    port_free_s = '0;
    i_free_s    = 1'b0;
    d_free_s    = 1'b0;
    // A port being released this cycle counts as free so handover has no bubble.
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_free_s[p] = (owner_r[p] == OWN_NONE) ||
                       ((owner_r[p] == OWN_I) && i_rel_s) ||
                       ((owner_r[p] == OWN_D) && d_rel_s);
      i_free_s = i_free_s | (port_free_s[p] & (i_I_portno == PORTNO_WIDTH'(p)));
      d_free_s = d_free_s | (port_free_s[p] & (i_D_portno == PORTNO_WIDTH'(p)));
    end
    conflict_s = i_cand_s && d_cand_s && i_inr_s && d_inr_s &&
                 (i_I_portno == i_D_portno) && i_free_s;
    // Out-of-range ports are granted unconditionally and never locked.
    i_grant_s = i_cand_s && (!i_inr_s || (i_free_s && !(conflict_s && d_pri_s)));
    d_grant_s = d_cand_s && (!d_inr_s || (d_free_s && !(conflict_s && !d_pri_s)));
    i_state_s = next_mstate(i_state_r, i_grant_s, i_I_req, i_I_done);
    d_state_s = next_mstate(d_state_r, d_grant_s, i_D_req, i_D_done);
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (i_grant_s && (i_I_portno == PORTNO_WIDTH'(p))) begin
        owner_s[p] = OWN_I;
      end else if (d_grant_s && (i_D_portno == PORTNO_WIDTH'(p))) begin
        owner_s[p] = OWN_D;
      end else if (port_free_s[p]) begin
        owner_s[p] = OWN_NONE;
      end else begin
        owner_s[p] = owner_r[p];
      end
    end
    wait_s = (i_state_r == M_WAIT) || (d_state_r == M_WAIT) ||
             (i_cand_s && !i_grant_s) || (d_cand_s && !d_grant_s);
    if (wait_s && (o_wait_cnt != 16'hFFFF)) begin
      wait_cnt_s = o_wait_cnt + 16'd1;
    end else begin
      wait_cnt_s = o_wait_cnt;
    end
  end

  // State, ownership and every output are registered here.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      i_state_r   <= M_IDLE;
      d_state_r   <= M_IDLE;
      o_I_gnt     <= 1'b0;
      o_D_gnt     <= 1'b0;
      o_I_mswitch <= '0;
      o_D_mswitch <= '0;
      sswitch_r   <= 5'b11111;
      o_wait_cnt  <= 16'd0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        owner_r[p] <= OWN_NONE;
      end
    end else begin
      i_state_r  <= i_state_s;
      d_state_r  <= d_state_s;
      o_I_gnt    <= (i_state_s == M_OWN);
      o_D_gnt    <= (d_state_s == M_OWN);
      o_wait_cnt <= wait_cnt_s;
      // mswitch keeps the last granted port after release.
      if (i_grant_s) o_I_mswitch <= i_I_portno;
      else o_I_mswitch <= o_I_mswitch;
      if (d_grant_s) o_D_mswitch <= i_D_portno;
      else o_D_mswitch <= o_D_mswitch;
      for (int p = 0; p < NUM_PORTS; p++) begin
        owner_r[p]   <= owner_s[p];
        sswitch_r[p] <= (owner_s[p] != OWN_I);
      end
    end
  end

  assign o_p0_sswitch = sswitch_r[0];
  assign o_p1_sswitch = sswitch_r[1];
  assign o_p2_sswitch = sswitch_r[2];
  assign o_p3_sswitch = sswitch_r[3];
  assign o_p4_sswitch = sswitch_r[4];

endmodule

// File: tb/tb_fabric2_port_arbiter.sv
// Self-checking bench for fabric2_port_arbiter: directed scenarios plus
// randomized protocol-legal traffic compared cycle by cycle against a
// behavioural ownership model.
module tb_fabric2_port_arbiter;

  localparam int PW     = 11;
  localparam int NPORTS = 5;
  localparam int ST_IDLE = 0;
  localparam int ST_WAIT = 1;
  localparam int ST_OWN  = 2;
`ifdef FABRIC2_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          i_I_req, i_I_done, i_D_req, i_D_done;
  logic [PW-1:0] i_I_portno, i_D_portno;
  logic          o_I_gnt, o_D_gnt;
  logic [PW-1:0] o_I_mswitch, o_D_mswitch;
  logic          o_p0_sswitch, o_p1_sswitch, o_p2_sswitch, o_p3_sswitch, o_p4_sswitch;
  logic [15:0]   o_wait_cnt;

  // Stimulus, index 0 = I master, 1 = D master.
  bit req [2];
  int port [2];
  bit done [2];

  // Reference model state.
  int m_st [2];
  int m_msw [2];
  int m_owner [NPORTS];   // -1 none, 0 I, 1 D
  int m_cnt;
  bit m_rr_next_d;

  int n_checks = 0;
  int n_errors = 0;

  assign i_I_req    = req[0];
  assign i_I_portno = PW'(port[0]);
  assign i_I_done   = done[0];
  assign i_D_req    = req[1];
  assign i_D_portno = PW'(port[1]);
  assign i_D_done   = done[1];

  always #5 clk = ~clk;

  fabric2_port_arbiter #(.PORTNO_WIDTH(PW)) dut (
    .clk(clk), .nrst(nrst),
    .i_I_req(i_I_req), .i_I_portno(i_I_portno), .i_I_done(i_I_done),
    .i_D_req(i_D_req), .i_D_portno(i_D_portno), .i_D_done(i_D_done),
    .o_I_gnt(o_I_gnt), .o_D_gnt(o_D_gnt),
    .o_I_mswitch(o_I_mswitch), .o_D_mswitch(o_D_mswitch),
    .o_p0_sswitch(o_p0_sswitch), .o_p1_sswitch(o_p1_sswitch),
    .o_p2_sswitch(o_p2_sswitch), .o_p3_sswitch(o_p3_sswitch),
    .o_p4_sswitch(o_p4_sswitch),
    .o_wait_cnt(o_wait_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      m_st[m]  = ST_IDLE;
      m_msw[m] = 0;
    end
    for (int p = 0; p < NPORTS; p++) m_owner[p] = -1;
    m_cnt       = 0;
    m_rr_next_d = 1'b1;
  endfunction

  // One clock edge of the arbitration rules, using the current stimulus.
  function automatic void model_edge();
    bit rel [2];
    bit cand [2];
    bit gr [2];
    bit waiting;
    int w;
    for (int m = 0; m < 2; m++) begin
      rel[m]  = done[m] && (m_st[m] == ST_OWN);
      cand[m] = req[m] && (m_st[m] != ST_OWN);
      gr[m]   = 1'b0;
    end
    for (int m = 0; m < 2; m++) begin
      if (cand[m]) begin
        if (port[m] >= NPORTS) gr[m] = 1'b1;
        else if (m_owner[port[m]] < 0 || rel[m_owner[port[m]]]) gr[m] = 1'b1;
      end
    end
    if (gr[0] && gr[1] && port[0] == port[1] && port[0] < NPORTS) begin
      w = (RR && !m_rr_next_d) ? 0 : 1;
      gr[1-w] = 1'b0;
      if (RR) m_rr_next_d = (w == 0);
    end
    waiting = (m_st[0] == ST_WAIT) || (m_st[1] == ST_WAIT) ||
              (cand[0] && !gr[0]) || (cand[1] && !gr[1]);
    for (int p = 0; p < NPORTS; p++)
      if (m_owner[p] >= 0 && rel[m_owner[p]]) m_owner[p] = -1;
    for (int m = 0; m < 2; m++)
      if (gr[m] && port[m] < NPORTS) m_owner[port[m]] = m;
    for (int m = 0; m < 2; m++) begin
      if (m_st[m] == ST_OWN) m_st[m] = done[m] ? ST_IDLE : ST_OWN;
      else if (gr[m]) begin
        m_st[m]  = ST_OWN;
        m_msw[m] = port[m];
      end else m_st[m] = req[m] ? ST_WAIT : ST_IDLE;
    end
    if (waiting && m_cnt < 65535) m_cnt++;
  endfunction

  function automatic logic [63:0] model_vec();
    logic [4:0] ssw;
    for (int p = 0; p < NPORTS; p++) ssw[p] = (m_owner[p] != 0);
    return {19'd0, m_st[0] == ST_OWN, m_st[1] == ST_OWN, PW'(m_msw[0]), PW'(m_msw[1]),
            ssw, 16'(m_cnt)};
  endfunction

  function automatic logic [63:0] dut_vec();
    return {19'd0, o_I_gnt, o_D_gnt, o_I_mswitch, o_D_mswitch,
            o_p4_sswitch, o_p3_sswitch, o_p2_sswitch, o_p1_sswitch, o_p0_sswitch, o_wait_cnt};
  endfunction

  function automatic logic [4:0] ssw_vec();
    return {o_p4_sswitch, o_p3_sswitch, o_p2_sswitch, o_p1_sswitch, o_p0_sswitch};
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_eq("outs", dut_vec(), model_vec());
  endtask

  task automatic cyc(input bit ir, input int ip, input bit id,
                     input bit dr, input int dp, input bit dd);
    req[0] = ir; port[0] = ip; done[0] = id;
    req[1] = dr; port[1] = dp; done[1] = dd;
    step();
  endtask

  // Asynchronous reset applied mid-cycle, checked before any clock edge.
  task automatic do_reset();
    #2;
    nrst = 1'b0;
    for (int m = 0; m < 2; m++) begin
      req[m] = 1'b0; done[m] = 1'b0; port[m] = 0;
    end
    #1;
    check_eq("rst_gnt", {o_I_gnt, o_D_gnt}, 2'b00);
    check_eq("rst_ssw", ssw_vec(), 5'b11111);
    check_eq("rst_msw", {o_I_mswitch, o_D_mswitch}, 22'd0);
    check_eq("rst_cnt", o_wait_cnt, 16'd0);
    model_reset();
    @(negedge clk);
    nrst = 1'b1;
    step();
  endtask

  task automatic rand_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      for (int m = 0; m < 2; m++) begin
        if (m_st[m] == ST_OWN) begin
          req[m]  = 1'b0;
          done[m] = ($urandom_range(3) == 0);
        end else begin
          done[m] = 1'b0;
          if (req[m]) begin
            if ($urandom_range(15) == 0) req[m] = 1'b0;
          end else if ($urandom_range(2) == 0) begin
            req[m]  = 1'b1;
            port[m] = ($urandom_range(9) < 7) ? int'($urandom_range(2)) : int'($urandom_range(7));
          end
        end
      end
      step();
    end
  endtask

  initial begin
    bit exp_d;
    for (int m = 0; m < 2; m++) begin
      req[m] = 1'b0; done[m] = 1'b0; port[m] = 0;
    end
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    rand_cycles(1500);
    do_reset();   // mid-run reset

    // Different ports in the same cycle: both granted.
    cyc(1'b1, 2, 1'b0, 1'b1, 3, 1'b0);
    check_eq("t2_gnt", {o_I_gnt, o_D_gnt}, 2'b11);
    check_eq("t2_p2", o_p2_sswitch, 1'b0);
    check_eq("t2_p3", o_p3_sswitch, 1'b1);
    check_eq("t2_msw", {o_I_mswitch, o_D_mswitch}, {11'd2, 11'd3});
    check_eq("t2_cnt", o_wait_cnt, 16'd0);
    cyc(1'b0, 2, 1'b1, 1'b0, 3, 1'b1);
    check_eq("t2_rel", {o_I_gnt, o_D_gnt}, 2'b00);

    // Same-port conflict, D wins, handover with no bubble.
    do_reset();
    cyc(1'b1, 1, 1'b0, 1'b1, 1, 1'b0);
    check_eq("t3_win", {o_I_gnt, o_D_gnt}, 2'b01);
    check_eq("t3_p1d", o_p1_sswitch, 1'b1);
    repeat (3) cyc(1'b1, 1, 1'b0, 1'b0, 1, 1'b0);
    cyc(1'b1, 1, 1'b0, 1'b0, 1, 1'b1);
    check_eq("t3_hand", {o_I_gnt, o_D_gnt}, 2'b10);
    check_eq("t3_p1i", o_p1_sswitch, 1'b0);
    check_eq("t3_cnt", o_wait_cnt, 16'd5);
    cyc(1'b0, 1, 1'b1, 1'b0, 1, 1'b0);

    // Three back-to-back port-0 conflicts.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      exp_d = RR ? (k % 2 == 0) : 1'b1;
      cyc(1'b1, 0, 1'b0, 1'b1, 0, 1'b0);
      check_eq($sformatf("rr_win%0d", k), {o_I_gnt, o_D_gnt}, {~exp_d, exp_d});
      if (exp_d) cyc(1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
      else cyc(1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
    end

    // Out-of-range port: granted, no lock, mswitch shows the port.
    do_reset();
    cyc(1'b1, 7, 1'b0, 1'b0, 0, 1'b0);
    check_eq("oor_gnt", o_I_gnt, 1'b1);
    check_eq("oor_msw", o_I_mswitch, 11'd7);
    check_eq("oor_ssw", ssw_vec(), 5'b11111);
    cyc(1'b0, 7, 1'b1, 1'b0, 0, 1'b0);
    check_eq("oor_rel", o_I_gnt, 1'b0);
    check_eq("oor_hold", o_I_mswitch, 11'd7);
    check_eq("oor_ssw2", ssw_vec(), 5'b11111);

    do_reset();
    rand_cycles(1500);

    // Long hold on port 4: wait counter saturates.
    do_reset();
    cyc(1'b1, 4, 1'b0, 1'b1, 4, 1'b0);
    repeat (70000) cyc(1'b1, 4, 1'b0, 1'b0, 4, 1'b0);
    check_eq("sat_cnt", o_wait_cnt, 16'hFFFF);
    cyc(1'b1, 4, 1'b0, 1'b0, 4, 1'b1);
    check_eq("sat_hand", {o_I_gnt, o_D_gnt}, 2'b10);
    check_eq("sat_p4", o_p4_sswitch, 1'b0);
    check_eq("sat_cnt2", o_wait_cnt, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
